// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate L1 data cache controller.
// Hits complete in the same cycle; misses stall through write-back and refill.
module dcache_ctrl #(
  parameter int INDEX_W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cpu_req_i,
  input  logic         cpu_we_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [31:0]  cpu_wdata_i,
  output logic [31:0]  cpu_rdata_o,
  output logic         cpu_stall_o,
  output logic         mem_req_o,
  output logic         mem_we_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_wdata_o,
  input  logic [255:0] mem_rdata_i,
  input  logic         mem_ack_i
);

  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = 27 - INDEX_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WB    = 2'd1;
  localparam logic [1:0] S_ALLOC = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nx;
  logic [LINES-1:0] valid;
  logic [LINES-1:0] dirty;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [255:0]     data_q [LINES];

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   ctag;
  logic [2:0]         wsel;
  logic [7:0]         wbit;
  logic [255:0]       line;
  logic               st_wb;
  logic               st_alloc;
  logic               hit;
  logic               refill;

  assign idx  = cpu_addr_i[5+INDEX_W-1:5];
  assign ctag = cpu_addr_i[31:5+INDEX_W];
  assign wsel = cpu_addr_i[4:2];
  assign wbit = {wsel, 5'b0};
  assign line = data_q[idx];

  assign st_wb    = (state == S_WB);
  assign st_alloc = (state == S_ALLOC);

  assign hit = cpu_req_i & valid[idx]
             & (tag_q[idx] == ctag)
             & (state == S_IDLE);

  assign cpu_stall_o = cpu_req_i & ~hit;
  assign cpu_rdata_o = cpu_req_i ? line[wbit +: 32] : 32'h0;

  // Acks only count while a request is outstanding.
  assign refill = st_alloc & mem_ack_i;

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (cpu_req_i & ~hit)
          state_nx = (valid[idx] & dirty[idx]) ? S_WB : S_ALLOC;
      end
      S_WB: begin
        if (mem_ack_i)
          state_nx = S_ALLOC;
      end
      S_ALLOC: begin
        if (mem_ack_i)
          state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = 32'h0;
    mem_wdata_o = '0;
    unique case (1'b1)
      st_wb: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {tag_q[idx], idx, 5'b0};
        mem_wdata_o = line;
      end
      st_alloc: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {ctag, idx, 5'b0};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= S_IDLE;
      valid <= '0;
      dirty <= '0;
    end else begin
      state <= state_nx;
      if (hit & cpu_we_i)
        dirty[idx] <= 1'b1;
      if (refill) begin
        valid[idx] <= 1'b1;
        dirty[idx] <= 1'b0;
      end
    end
  end

  // Tag and data arrays carry no reset; valid gates their use.
  always_ff @(posedge clk_i) begin
    if (hit & cpu_we_i)
      data_q[idx][wbit +: 32] <= cpu_wdata_i;
    if (refill) begin
      data_q[idx] <= mem_rdata_i;
      tag_q[idx]  <= ctag;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a latency-3 backing memory model.
// Expected loads and memory transactions are queued and popped on output.
module tb_dcache_ctrl;

  localparam int LAT = 3;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         cpu_req_i;
  logic         cpu_we_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_wdata_i;
  logic [31:0]  cpu_rdata_o;
  logic         cpu_stall_o;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_wdata_o;
  logic [255:0] mem_rdata_i;
  logic         mem_ack_i;

  dcache_ctrl #(.INDEX_W(4)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cpu_req_i   (cpu_req_i),
    .cpu_we_i    (cpu_we_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_wdata_i (cpu_wdata_i),
    .cpu_rdata_o (cpu_rdata_o),
    .cpu_stall_o (cpu_stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ack_i   (mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    int          wsel;
    logic [31:0] word;
  } txn_t;

  txn_t         exp_txn [$];
  logic [31:0]  exp_rd  [$];
  logic [255:0] memimg  [logic [31:0]];
  logic [31:0]  cpuview [logic [31:0]];

  int n_assert = 0;
  int n_fail   = 0;
  int cnt      = 0;

  function automatic logic [31:0] init_word(logic [31:0] a);
    logic [31:0] w;
    w = {29'd0, a[4:2]} + 32'd1;
    return (w * 32'h1111_1111) ^ {a[16:9], 24'h0};
  endfunction

  function automatic logic [255:0] line_of(logic [31:0] la);
    logic [255:0] l;
    if (memimg.exists(la)) return memimg[la];
    for (int i = 0; i < 8; i++)
      l[i*32 +: 32] = init_word(la + 32'(i * 4));
    return l;
  endfunction

  function automatic logic [31:0] exp_word(logic [31:0] a);
    if (cpuview.exists(a)) return cpuview[a];
    return init_word(a);
  endfunction

  task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic exp_fetch(logic [31:0] a);
    txn_t t;
    t.we = 1'b0; t.addr = a; t.wsel = -1; t.word = 32'h0;
    exp_txn.push_back(t);
  endtask

  task automatic exp_wb(logic [31:0] a, int ws, logic [31:0] w);
    txn_t t;
    t.we = 1'b1; t.addr = a; t.wsel = ws; t.word = w;
    exp_txn.push_back(t);
  endtask

  task automatic mem_tick();
    txn_t t;
    mem_ack_i = 1'b0;
    if (mem_req_o) begin
      cnt++;
      if (cnt == LAT) begin
        cnt = 0;
        mem_ack_i = 1'b1;
        chk("txn_expected", 256'(exp_txn.size() != 0), 256'd1);
        if (exp_txn.size() != 0) begin
          t = exp_txn.pop_front();
          chk("txn_we", 256'(mem_we_o), 256'(t.we));
          chk("txn_addr", 256'(mem_addr_o), 256'(t.addr));
          if (mem_we_o) begin
            memimg[mem_addr_o] = mem_wdata_o;
            if (t.wsel >= 0)
              chk("wb_word", 256'(mem_wdata_o[t.wsel*32 +: 32]), 256'(t.word));
          end else begin
            mem_rdata_i = line_of(mem_addr_o);
          end
        end
      end
    end
  endtask

  task automatic access(string tag, logic we, logic [31:0] a,
                        logic [31:0] wd, int stalls);
    int n;
    logic done;
    logic [31:0] rd;
    cpu_req_i = 1'b1; cpu_we_i = we;
    cpu_addr_i = a; cpu_wdata_i = wd;
    if (!we) exp_rd.push_back(exp_word(a));
    else cpuview[a] = wd;
    n = 0; done = 1'b0;
    while (!done && n < 60) begin
      #1;
      mem_tick();
      if (!cpu_stall_o) done = 1'b1;
      else begin
        n++;
        @(negedge clk_i);
      end
    end
    chk({tag, "_done"}, 256'(done), 256'd1);
    chk({tag, "_stalls"}, 256'(n), 256'(stalls));
    chk({tag, "_memreq"}, 256'(mem_req_o), 256'd0);
    chk({tag, "_wdata0"}, mem_wdata_o, 256'd0);
    chk({tag, "_txnleft"}, 256'(exp_txn.size()), 256'd0);
    if (!we) begin
      rd = exp_rd.pop_front();
      chk({tag, "_rdata"}, 256'(cpu_rdata_o), 256'(rd));
    end
    @(negedge clk_i);
    cpu_req_i = 1'b0; cpu_we_i = 1'b0;
    #1;
    chk({tag, "_idle_rd"}, 256'(cpu_rdata_o), 256'd0);
    chk({tag, "_idle_st"}, 256'(cpu_stall_o), 256'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b0; cpu_req_i = 1'b0; cpu_we_i = 1'b0;
    cpu_addr_i = '0; cpu_wdata_i = '0;
    mem_rdata_i = '0; mem_ack_i = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    chk("rst_stall", 256'(cpu_stall_o), 256'd0);
    chk("rst_memreq", 256'(mem_req_o), 256'd0);
    chk("rst_rdata", 256'(cpu_rdata_o), 256'd0);
    @(negedge clk_i);
    rst_i = 1'b1;

    exp_fetch(32'h40);
    access("cold_ld40", 1'b0, 32'h40, 32'h0, 4);
    chk("cold_word0", 256'(init_word(32'h40)), 256'h1111_1111);
    access("hit_ld44", 1'b0, 32'h44, 32'h0, 0);
    access("hit_st48", 1'b1, 32'h48, 32'hDEAD_BEEF, 0);
    access("hit_ld48", 1'b0, 32'h48, 32'h0, 0);

    exp_wb(32'h40, 2, 32'hDEAD_BEEF);
    exp_fetch(32'h240);
    access("evict_ld240", 1'b0, 32'h240, 32'h0, 7);

    exp_fetch(32'hA0);
    access("miss_stA0", 1'b1, 32'hA0, 32'h5, 4);
    access("hit_ldA0", 1'b0, 32'hA0, 32'h0, 0);

    exp_wb(32'hA0, 0, 32'h5);
    exp_fetch(32'h4A0);
    access("evict_ld4A0", 1'b0, 32'h4A0, 32'h0, 7);

    exp_fetch(32'h40);
    access("wrap_ld48", 1'b0, 32'h48, 32'h0, 4);

    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h300;
    #1;
    chk("ra_stall0", 256'(cpu_stall_o), 256'd1);
    chk("ra_req0", 256'(mem_req_o), 256'd0);
    @(negedge clk_i);
    #1;
    chk("ra_req1", 256'(mem_req_o), 256'd1);
    chk("ra_we1", 256'(mem_we_o), 256'd0);
    chk("ra_addr1", 256'(mem_addr_o), 256'h300);
    @(negedge clk_i);
    #1;
    rst_i = 1'b0;
    #1;
    chk("ra_req_drop", 256'(mem_req_o), 256'd0);
    chk("ra_stall_rst", 256'(cpu_stall_o), 256'd1);
    cpu_req_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1; cnt = 0; mem_ack_i = 1'b0;
    #1;

    exp_fetch(32'h40);
    access("post_rst_ld48", 1'b0, 32'h48, 32'h0, 4);
    exp_fetch(32'h300);
    access("post_rst_ld300", 1'b0, 32'h300, 32'h0, 4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
